// File: rtl/bank_ram_pkg.sv
// Shared definitions for the bank RAM bus arbiter: arbitration mode codes,
// the buffered write-command record and a width helper that stays >= 1.
package bank_ram_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Index width for a field that must address n items; never returns 0,
  // so a single-master build still has a 1-bit ID.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Default geometry; the top-level parameters default to these values and
  // the write-command record below is sized from them.
  localparam int PKG_NUM_SLOTS  = 4;
  localparam int PKG_NUM_BANKS  = 5;
  localparam int PKG_ADDR_WIDTH = 9;
  localparam int SRC_W          = clog2_min1(PKG_NUM_SLOTS);

  // One pending write: which master owns it, and where it goes.
  typedef struct packed {
    logic [SRC_W-1:0]          src;
    logic [PKG_NUM_BANKS-1:0]  mask;
    logic [PKG_ADDR_WIDTH-1:0] addr;
  } wr_cmd_t;

endpackage

// File: rtl/bank_ram_bus_rr_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with synchronous active-high
// reset. dout_o always shows the head entry while empty_o is low.
// Push while full and pop while empty are ignored.
module sync_fifo
  import bank_ram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4   // power of 2, >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = clog2_min1(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Pointer next-state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
  end

  // Pointer registers; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
  end

endmodule

// File: rtl/bank_ram_bus_rr.sv
// Multi-master arbiter in front of the SIMD bank RAM. Masters issue masked
// read/write commands; writes are queued with their source and issued when
// the owning master presents write data and the phy is ready; reads go
// straight to the phy and their source IDs are queued so returning data is
// routed back. Read returns with no outstanding ID raise a sticky error.
// Optional build macro BANK_RAM_BUS_PERF_EN adds per-slot grant counters and
// a stall counter as extra output ports.
module bank_ram_bus_rr
  import bank_ram_pkg::*;
#(
  parameter int NUM_SLOTS     = PKG_NUM_SLOTS,
  parameter int NUM_BANKS     = PKG_NUM_BANKS,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = PKG_ADDR_WIDTH,
  parameter int WR_FIFO_DEPTH = 4,
  parameter int RD_FIFO_DEPTH = 8,
  parameter int ARB_MODE      = ARB_RR
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_SLOTS-1:0]                     slot_cmd_valid_i,
  input  logic [NUM_SLOTS-1:0]                     slot_cmd_rw_i,
  input  logic [NUM_SLOTS*NUM_BANKS-1:0]           slot_cmd_mask_i,
  input  logic [NUM_SLOTS*ADDR_WIDTH-1:0]          slot_cmd_addr_i,
  output logic [NUM_SLOTS-1:0]                     slot_cmd_ready_o,
  input  logic [NUM_SLOTS-1:0]                     slot_wvalid_i,
  input  logic [NUM_SLOTS*NUM_BANKS*DATA_WIDTH-1:0] slot_wdata_i,
  output logic [NUM_SLOTS-1:0]                     slot_wready_o,
  output logic [NUM_SLOTS-1:0]                     slot_rvalid_o,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]          slot_rdata_o,
  output logic                                     phy_cmd_valid_o,
  output logic                                     phy_cmd_rw_o,
  output logic [NUM_BANKS-1:0]                     phy_cmd_mask_o,
  output logic [ADDR_WIDTH-1:0]                    phy_cmd_addr_o,
  input  logic                                     phy_cmd_ready_i,
  output logic                                     phy_wvalid_o,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]          phy_wdata_o,
  input  logic                                     phy_rvalid_i,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]          phy_rdata_i,
  output logic                                     err_rd_orphan_o
`ifdef BANK_RAM_BUS_PERF_EN
  ,
  output logic [NUM_SLOTS*16-1:0]                  perf_grant_cnt_o,
  output logic [15:0]                              perf_stall_cnt_o
`endif
);

  localparam int SLOT_W = clog2_min1(NUM_SLOTS);
  localparam int LINE_W = NUM_BANKS * DATA_WIDTH;

  // Per-slot views of the flattened command and write-data buses.
  logic [NUM_BANKS-1:0]  cmd_mask [NUM_SLOTS];
  logic [ADDR_WIDTH-1:0] cmd_addr [NUM_SLOTS];
  logic [LINE_W-1:0]     wdata    [NUM_SLOTS];

  // Arbitration.
  logic              win_found;
  logic [SLOT_W-1:0] win_idx;
  logic [SLOT_W-1:0] cand;
  logic [SLOT_W-1:0] rr_ptr_q, rr_ptr_d;

  // Handshake decisions for this cycle.
  logic wr_acc, rd_acc, cmd_acc, wr_issue, rd_ret;

  // FIFO interfaces.
  wr_cmd_t           wr_push_data, wr_head;
  logic              wr_full, wr_empty;
  logic [SLOT_W-1:0] id_head;
  logic              id_full, id_empty;

  logic err_q, err_d;

  // Unpack the flattened per-slot buses.
  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      cmd_mask[s] = slot_cmd_mask_i[s*NUM_BANKS +: NUM_BANKS];
      cmd_addr[s] = slot_cmd_addr_i[s*ADDR_WIDTH +: ADDR_WIDTH];
      wdata[s]    = slot_wdata_i[s*LINE_W +: LINE_W];
    end
  end

  // Pick the winner: lowest index in fixed mode, first requester at or
  // after rr_ptr_q in round-robin mode.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (ARB_MODE == ARB_RR) cand = SLOT_W'((int'(rr_ptr_q) + i) % NUM_SLOTS);
      else                    cand = SLOT_W'(i);
      if (!win_found && slot_cmd_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Handshake decisions. A queued write owns the phy port whenever it can
  // go; reads additionally wait for the write queue to drain so they never
  // overtake an earlier write.
  always_comb begin
    wr_issue = !wr_empty && slot_wvalid_i[wr_head.src] && phy_cmd_ready_i;
    wr_acc   = win_found && slot_cmd_rw_i[win_idx] && !wr_full;
    rd_acc   = win_found && !slot_cmd_rw_i[win_idx] && wr_empty && !id_full &&
               phy_cmd_ready_i && !wr_issue;
    cmd_acc  = wr_acc || rd_acc;
    rd_ret   = phy_rvalid_i && !id_empty;
  end

  // Write-command record for the queue.
  always_comb begin
    wr_push_data.src  = win_idx;
    wr_push_data.mask = cmd_mask[win_idx];
    wr_push_data.addr = cmd_addr[win_idx];
  end

  sync_fifo #(
    .WIDTH ($bits(wr_cmd_t)),
    .DEPTH (WR_FIFO_DEPTH)
  ) u_wr_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_acc),
    .din_i   (wr_push_data),
    .pop_i   (wr_issue),
    .dout_o  (wr_head),
    .full_o  (wr_full),
    .empty_o (wr_empty)
  );

  sync_fifo #(
    .WIDTH (SLOT_W),
    .DEPTH (RD_FIFO_DEPTH)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rd_acc),
    .din_i   (win_idx),
    .pop_i   (rd_ret),
    .dout_o  (id_head),
    .full_o  (id_full),
    .empty_o (id_empty)
  );

  // Command-side and phy-side outputs; data buses are zero when idle.
  always_comb begin
    slot_cmd_ready_o = '0;
    slot_wready_o    = '0;
    phy_cmd_valid_o  = 1'b0;
    phy_cmd_rw_o     = 1'b0;
    phy_cmd_mask_o   = '0;
    phy_cmd_addr_o   = '0;
    phy_wvalid_o     = 1'b0;
    phy_wdata_o      = '0;
    if (cmd_acc) slot_cmd_ready_o[win_idx] = 1'b1;
    if (wr_issue) begin
      phy_cmd_valid_o            = 1'b1;
      phy_cmd_rw_o               = 1'b1;
      phy_cmd_mask_o             = wr_head.mask;
      phy_cmd_addr_o             = wr_head.addr;
      phy_wvalid_o               = 1'b1;
      phy_wdata_o                = wdata[wr_head.src];
      slot_wready_o[wr_head.src] = 1'b1;
    end else if (rd_acc) begin
      phy_cmd_valid_o = 1'b1;
      phy_cmd_mask_o  = cmd_mask[win_idx];
      phy_cmd_addr_o  = cmd_addr[win_idx];
    end
  end

  // Read-return routing: data is broadcast, valid goes to the head ID.
  always_comb begin
    slot_rvalid_o = '0;
    if (rd_ret) slot_rvalid_o[id_head] = 1'b1;
    slot_rdata_o = phy_rdata_i;
  end

  // Next-state for the round-robin pointer and the orphan flag.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (cmd_acc) rr_ptr_d = SLOT_W'((int'(win_idx) + 1) % NUM_SLOTS);
    err_d = err_q || (phy_rvalid_i && id_empty);
  end

  // Round-robin pointer and sticky orphan-return flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  assign err_rd_orphan_o = err_q;

`ifdef BANK_RAM_BUS_PERF_EN
  logic [15:0] grant_cnt_q [NUM_SLOTS];
  logic [15:0] stall_cnt_q;

  // Saturating grant-per-slot and stalled-request cycle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SLOTS; s++) grant_cnt_q[s] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (slot_cmd_ready_o[s] && grant_cnt_q[s] != 16'hFFFF)
          grant_cnt_q[s] <= grant_cnt_q[s] + 16'd1;
      end
      if (|slot_cmd_valid_i && !cmd_acc && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  // Flatten the grant counters onto the output port.
  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) perf_grant_cnt_o[s*16 +: 16] = grant_cnt_q[s];
  end

  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bank_ram_bus_rr.sv
// Self-checking bench for bank_ram_bus_rr (default build, round-robin).
module tb_bank_ram_bus_rr;

  localparam int NS = 4;
  localparam int NB = 5;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int LW = NB * DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NS-1:0]    cmd_valid, cmd_rw, cmd_ready, wvalid, wready, rvalid;
  logic [NS*NB-1:0] cmd_mask;
  logic [NS*AW-1:0] cmd_addr;
  logic [NS*LW-1:0] wdata_v;
  logic [LW-1:0]    rdata;
  logic             phy_cmd_valid, phy_cmd_rw, phy_cmd_ready, phy_wvalid, phy_rvalid;
  logic [NB-1:0]    phy_cmd_mask;
  logic [AW-1:0]    phy_cmd_addr;
  logic [LW-1:0]    phy_wdata, phy_rdata;
  logic             err_orphan;

  bank_ram_bus_rr dut (
    .clk              (clk),
    .rst              (rst),
    .slot_cmd_valid_i (cmd_valid),
    .slot_cmd_rw_i    (cmd_rw),
    .slot_cmd_mask_i  (cmd_mask),
    .slot_cmd_addr_i  (cmd_addr),
    .slot_cmd_ready_o (cmd_ready),
    .slot_wvalid_i    (wvalid),
    .slot_wdata_i     (wdata_v),
    .slot_wready_o    (wready),
    .slot_rvalid_o    (rvalid),
    .slot_rdata_o     (rdata),
    .phy_cmd_valid_o  (phy_cmd_valid),
    .phy_cmd_rw_o     (phy_cmd_rw),
    .phy_cmd_mask_o   (phy_cmd_mask),
    .phy_cmd_addr_o   (phy_cmd_addr),
    .phy_cmd_ready_i  (phy_cmd_ready),
    .phy_wvalid_o     (phy_wvalid),
    .phy_wdata_o      (phy_wdata),
    .phy_rvalid_i     (phy_rvalid),
    .phy_rdata_i      (phy_rdata),
    .err_rd_orphan_o  (err_orphan)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned sb_q[$];   // expected read-return slot IDs, oldest first
  int grants[NS];
  int rr_m;

  typedef struct {
    logic [NS-1:0] valid;
    logic [NS-1:0] exp_ready;
  } arb_vec_t;
  arb_vec_t vecs[8];

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NS-1:0] oh(input int i);
    logic [NS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Inputs change 1 time unit after the rising edge; checks run on the falling edge.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int k, input logic rw, input logic [NB-1:0] m, input logic [AW-1:0] a);
    cmd_rw[k]          = rw;
    cmd_mask[k*NB +: NB] = m;
    cmd_addr[k*AW +: AW] = a;
  endtask

  task automatic idle_inputs();
    cmd_valid     = '0;
    cmd_rw        = '0;
    wvalid        = '0;
    phy_cmd_ready = 1'b1;
    phy_rvalid    = 1'b0;
    phy_rdata     = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    adv();
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("rst cmd_ready", cmd_ready, '0);
    check("rst wready", wready, '0);
    check("rst rvalid", rvalid, '0);
    check("rst phy_cmd_valid", phy_cmd_valid, '0);
    check("rst phy_wvalid", phy_wvalid, '0);
    check("rst phy_mask", phy_cmd_mask, '0);
    check("rst phy_addr", phy_cmd_addr, '0);
    check("rst phy_wdata", phy_wdata, '0);
    check("rst err_orphan", err_orphan, '0);
    adv();
  endtask

  // Return every outstanding read in order and check routing and data.
  task automatic drain_reads(input string tag);
    logic [LW-1:0] d;
    cmd_valid = '0;
    while (sb_q.size() > 0) begin
      d          = rand_line();
      phy_rvalid = 1'b1;
      phy_rdata  = d;
      @(negedge clk);
      check({tag, " rvalid"}, rvalid, oh(sb_q[0]));
      check({tag, " rdata"}, rdata, d);
      void'(sb_q.pop_front());
      adv();
    end
    phy_rvalid = 1'b0;
    @(negedge clk);
    check({tag, " idle rvalid"}, rvalid, '0);
    check({tag, " no orphan"}, err_orphan, '0);
    adv();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    cmd_mask = '0;
    cmd_addr = '0;
    wdata_v  = '0;
    idle_inputs();

    // Round-robin pattern table, reads only, pointer starts at 0.
    vecs[0] = '{4'b1111, 4'b0001};
    vecs[1] = '{4'b1111, 4'b0010};
    vecs[2] = '{4'b1001, 4'b1000};
    vecs[3] = '{4'b0110, 4'b0010};
    vecs[4] = '{4'b0000, 4'b0000};
    vecs[5] = '{4'b0001, 4'b0001};
    vecs[6] = '{4'b1100, 4'b0100};
    vecs[7] = '{4'b1111, 4'b1000};

    do_reset();
    for (int k = 0; k < NS; k++) set_slot(k, 1'b0, NB'(k + 1), AW'(9'h040 + k));
    for (int v = 0; v < 8; v++) begin
      cmd_valid = vecs[v].valid;
      @(negedge clk);
      check($sformatf("arb[%0d] cmd_ready", v), cmd_ready, vecs[v].exp_ready);
      check($sformatf("arb[%0d] phy_valid", v), phy_cmd_valid, |vecs[v].exp_ready);
      for (int k = 0; k < NS; k++) begin
        if (vecs[v].exp_ready[k]) begin
          check($sformatf("arb[%0d] phy_addr", v), phy_cmd_addr, AW'(9'h040 + k));
          check($sformatf("arb[%0d] phy_mask", v), phy_cmd_mask, NB'(k + 1));
          sb_q.push_back(k);
        end
      end
      adv();
    end
    drain_reads("arb");

    // All four slots reading back-to-back for 100 grants; returns overlap.
    do_reset();
    rr_m = 0;
    for (int k = 0; k < NS; k++) grants[k] = 0;
    cmd_valid = '1;
    cmd_rw    = '0;
    for (int c = 0; c < 100; c++) begin
      logic [LW-1:0] d;
      d          = rand_line();
      phy_rvalid = (sb_q.size() > 0);
      phy_rdata  = d;
      @(negedge clk);
      check("rr100 cmd_ready", cmd_ready, oh(rr_m));
      if (sb_q.size() > 0) begin
        check("rr100 rvalid", rvalid, oh(sb_q[0]));
        check("rr100 rdata", rdata, d);
        void'(sb_q.pop_front());
      end
      for (int k = 0; k < NS; k++) if (cmd_ready[k]) grants[k]++;
      sb_q.push_back(rr_m);
      rr_m = (rr_m + 1) % NS;
      adv();
    end
    phy_rvalid = 1'b0;
    for (int k = 0; k < NS; k++) check($sformatf("rr100 grants slot%0d", k), grants[k], 25);
    drain_reads("rr100");

    // Slot 2 write with write data arriving three cycles after acceptance.
    do_reset();
    set_slot(2, 1'b1, 5'b10101, 9'h015);
    wdata_v[2*LW +: LW] = rand_line();
    cmd_valid = 4'b0100;
    @(negedge clk);
    check("wr2 cmd_ready", cmd_ready, 4'b0100);
    check("wr2 accept no phy", phy_cmd_valid, 1'b0);
    adv();
    cmd_valid = '0;
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      check("wr2 wait phy_valid", phy_cmd_valid, 1'b0);
      check("wr2 wait wready", wready, '0);
      adv();
    end
    wvalid = 4'b0100;
    @(negedge clk);
    check("wr2 phy_valid", phy_cmd_valid, 1'b1);
    check("wr2 phy_rw", phy_cmd_rw, 1'b1);
    check("wr2 phy_wvalid", phy_wvalid, 1'b1);
    check("wr2 phy_wdata", phy_wdata, wdata_v[2*LW +: LW]);
    check("wr2 phy_mask", phy_cmd_mask, 5'b10101);
    check("wr2 phy_addr", phy_cmd_addr, 9'h015);
    check("wr2 wready", wready, 4'b0100);
    adv();
    wvalid = '0;
    @(negedge clk);
    check("wr2 after phy_valid", phy_cmd_valid, 1'b0);
    check("wr2 after wready", wready, '0);
    adv();

    // Read held behind a queued write until the write issues.
    do_reset();
    set_slot(1, 1'b1, 5'b11111, 9'h0AA);
    set_slot(0, 1'b0, 5'b00011, 9'h033);
    wdata_v[1*LW +: LW] = rand_line();
    cmd_valid = 4'b0010;
    @(negedge clk);
    check("raw wr cmd_ready", cmd_ready, 4'b0010);
    adv();
    cmd_valid = 4'b0001;
    @(negedge clk);
    check("raw rd blocked ready", cmd_ready, '0);
    check("raw rd blocked phy", phy_cmd_valid, 1'b0);
    adv();
    wvalid = 4'b0010;
    @(negedge clk);
    check("raw wr phy_valid", phy_cmd_valid, 1'b1);
    check("raw wr phy_rw", phy_cmd_rw, 1'b1);
    check("raw wr phy_addr", phy_cmd_addr, 9'h0AA);
    check("raw rd still held", cmd_ready, '0);
    adv();
    wvalid = '0;
    @(negedge clk);
    check("raw rd cmd_ready", cmd_ready, 4'b0001);
    check("raw rd phy_valid", phy_cmd_valid, 1'b1);
    check("raw rd phy_rw", phy_cmd_rw, 1'b0);
    check("raw rd phy_addr", phy_cmd_addr, 9'h033);
    check("raw rd phy_mask", phy_cmd_mask, 5'b00011);
    sb_q.push_back(0);
    adv();
    drain_reads("raw");

    // Write queue fills while the phy is stalled; fifth write is refused.
    do_reset();
    phy_cmd_ready = 1'b0;
    wvalid        = '1;
    for (int k = 0; k < NS; k++) begin
      set_slot(k, 1'b1, NB'(5'b00001 << k), AW'(9'h100 + k));
      wdata_v[k*LW +: LW] = rand_line();
    end
    for (int k = 0; k < NS; k++) begin
      cmd_valid = oh(k);
      @(negedge clk);
      check($sformatf("full push%0d ready", k), cmd_ready, oh(k));
      check($sformatf("full push%0d phy", k), phy_cmd_valid, 1'b0);
      adv();
    end
    set_slot(0, 1'b1, 5'b11111, 9'h1FF);
    cmd_valid = 4'b0001;
    @(negedge clk);
    check("full refuse ready", cmd_ready, '0);
    check("full refuse phy", phy_cmd_valid, 1'b0);
    check("full refuse wready", wready, '0);
    adv();
    cmd_valid     = '0;
    phy_cmd_ready = 1'b1;
    for (int k = 0; k < NS; k++) begin
      @(negedge clk);
      check($sformatf("full pop%0d phy_valid", k), phy_cmd_valid, 1'b1);
      check($sformatf("full pop%0d phy_addr", k), phy_cmd_addr, AW'(9'h100 + k));
      check($sformatf("full pop%0d phy_mask", k), phy_cmd_mask, NB'(5'b00001 << k));
      check($sformatf("full pop%0d phy_wdata", k), phy_wdata, wdata_v[k*LW +: LW]);
      check($sformatf("full pop%0d wready", k), wready, oh(k));
      adv();
    end
    @(negedge clk);
    check("full drained phy", phy_cmd_valid, 1'b0);
    adv();
    wvalid = '0;

    // Reads from slot 3 then slot 1, each returned two cycles later.
    do_reset();
    set_slot(3, 1'b0, 5'b11000, 9'h0C3);
    set_slot(1, 1'b0, 5'b00110, 9'h0C1);
    cmd_valid = 4'b1000;
    @(negedge clk);
    check("ret rd3 ready", cmd_ready, 4'b1000);
    sb_q.push_back(3);
    adv();
    cmd_valid = 4'b0010;
    @(negedge clk);
    check("ret rd1 ready", cmd_ready, 4'b0010);
    sb_q.push_back(1);
    adv();
    drain_reads("ret");

    // Reset with two reads in flight; the late return is an orphan.
    do_reset();
    set_slot(0, 1'b0, 5'b00001, 9'h010);
    set_slot(2, 1'b0, 5'b00100, 9'h012);
    cmd_valid = 4'b0001;
    @(negedge clk);
    check("orph rd0 ready", cmd_ready, 4'b0001);
    adv();
    cmd_valid = 4'b0100;
    @(negedge clk);
    check("orph rd2 ready", cmd_ready, 4'b0100);
    adv();
    cmd_valid = '0;
    rst       = 1'b1;
    adv();
    rst        = 1'b0;
    phy_rvalid = 1'b1;
    phy_rdata  = rand_line();
    @(negedge clk);
    check("orph no rvalid", rvalid, '0);
    check("orph err before", err_orphan, 1'b0);
    adv();
    phy_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("orph err sticky", err_orphan, 1'b1);
      adv();
    end
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
